// File: rtl/pool_flatten_stream.sv
// pool_flatten_stream: snapshots all pooled channel matrices once every channel is finished and streams them out channel-major over valid/ready.
module pool_flatten_stream #(
  parameter int DATAWIDTH        = 32,
  parameter int OUTPUT_DIMENSION = 13,
  parameter int CHANNEL_COUNT    = 2,
  localparam int TOTAL           = CHANNEL_COUNT * OUTPUT_DIMENSION * OUTPUT_DIMENSION,
  localparam int IDX_WIDTH       = $clog2(TOTAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] mat_in [CHANNEL_COUNT][OUTPUT_DIMENSION][OUTPUT_DIMENSION],
  input  logic                 finished [CHANNEL_COUNT],
  output logic [DATAWIDTH-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [IDX_WIDTH-1:0] idx_out,
  output logic                 last_out,
  output logic                 busy,
  output logic                 done
);
  localparam int OD = OUTPUT_DIMENSION;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [DATAWIDTH-1:0] flat [TOTAL];
  logic [DATAWIDTH-1:0] buf_q [TOTAL];
  logic all_done, capture, is_last;
  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_c
    for (genvar r = 0; r < OD; r++) begin : g_r
      for (genvar k = 0; k < OD; k++) begin : g_k
        assign flat[c*OD*OD + r*OD + k] = mat_in[c][r][k];
      end
    end
  end
  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < CHANNEL_COUNT; i++) all_done = all_done & finished[i];
  end
  assign capture = (state_q == S_IDLE) && all_done;
  assign is_last = idx_q == IDX_WIDTH'(TOTAL - 1);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (all_done) begin
        state_d = S_STREAM;
        idx_d   = '0;
      end
      S_STREAM: if (ready_in) begin
        state_d = is_last ? S_DONE : S_STREAM;
        idx_d   = is_last ? '0 : idx_q + IDX_WIDTH'(1);
      end
      S_DONE: state_d = all_done ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
  // Snapshot buffer is deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (capture) buf_q <= flat;
  end
  assign valid_out = state_q == S_STREAM;
  assign busy      = valid_out;
  assign done      = state_q == S_DONE;
  assign data_out  = valid_out ? buf_q[idx_q] : '0;
  assign idx_out   = idx_q;
  assign last_out  = valid_out && is_last;
endmodule

// File: tb/tb_pool_flatten_stream.sv
// tb_pool_flatten_stream: table checks on a known pattern plus randomized ready/data streams against a flattened-snapshot model.
module tb_pool_flatten_stream;
  localparam int DW = 32, OD = 13, CH = 2, TOTAL = CH * OD * OD;
  logic clk = 0, rst = 1, ready_in = 0;
  logic [DW-1:0] mat_in [CH][OD][OD];
  logic finished [CH];
  logic [DW-1:0] data_out;
  logic valid_out, last_out, busy, done;
  logic [8:0] idx_out;
  int checks = 0, failures = 0;
  logic [DW-1:0] exp_q [TOTAL];
  logic [DW-1:0] got [TOTAL];
  logic got_last [TOTAL];
  typedef struct {int beat; logic [DW-1:0] data; logic last;} vec_t;
  vec_t tbl [6];
  int span, nb;

  pool_flatten_stream dut (
    .clk(clk), .rst(rst), .mat_in(mat_in), .finished(finished),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .idx_out(idx_out), .last_out(last_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < OD; r++)
        for (int k = 0; k < OD; k++)
          mat_in[c][r][k] = mode == 0 ? 32'(c*1000 + r*16 + k) : mode == 1 ? $urandom : 32'hFFFF_FFFF;
  endtask

  task automatic snap();
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < OD; r++)
        for (int k = 0; k < OD; k++)
          exp_q[(c*OD + r)*OD + k] = mat_in[c][r][k];
  endtask

  task automatic set_fin(input logic a, input logic b);
    finished[0] = a;
    finished[1] = b;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_valid"}, 32'(valid_out), 0);
    chk({tag, "_idx"}, 32'(idx_out), 0);
    chk({tag, "_last"}, 32'(last_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Called just after a posedge; accepts beats until stop_at, checking order, data, last and stall stability.
  task automatic stream(input int pct, input int corrupt_at, input int stop_at, output int n, output int sp);
    int cyc = 0, first = -1, lastc = 0;
    logic stalled = 0;
    logic [DW-1:0] pd;
    logic [8:0] pi;
    logic pl;
    n = 0;
    while (n < stop_at && cyc < 6000) begin
      ready_in = $urandom_range(99) < pct;
      @(negedge clk);
      if (valid_out) begin
        if (first < 0) first = cyc;
        if (stalled) begin
          chk("stall_data", data_out, pd);
          chk("stall_idx", 32'(idx_out), 32'(pi));
          chk("stall_last", 32'(last_out), 32'(pl));
        end
        if (ready_in) begin
          chk("beat_idx", 32'(idx_out), 32'(n));
          chk("beat_data", data_out, exp_q[n]);
          chk("beat_last", 32'(last_out), 32'(n == TOTAL - 1));
          got[n] = data_out;
          got_last[n] = last_out;
          n++;
          lastc = cyc;
          if (n == corrupt_at) fill(2);
          stalled = 0;
        end else begin
          stalled = 1;
          pd = data_out;
          pi = idx_out;
          pl = last_out;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (n < stop_at) chk("stream_timeout", 32'(n), 32'(stop_at));
    sp = lastc - first + 1;
  endtask

  initial begin
    tbl[0] = '{0, 32'd0, 1'b0};
    tbl[1] = '{1, 32'd1, 1'b0};
    tbl[2] = '{13, 32'd16, 1'b0};
    tbl[3] = '{169, 32'd1000, 1'b0};
    tbl[4] = '{336, 32'd1203, 1'b0};
    tbl[5] = '{337, 32'd1204, 1'b1};
    set_fin(0, 0);
    fill(0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_idle_outs("reset");
    // Known pattern, ready held high
    @(posedge clk); #1;
    fill(0);
    snap();
    set_fin(1, 1);
    stream(100, -1, TOTAL, nb, span);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tbl_data_%0d", tbl[i].beat), got[tbl[i].beat], tbl[i].data);
      chk($sformatf("tbl_last_%0d", tbl[i].beat), 32'(got_last[tbl[i].beat]), 32'(tbl[i].last));
    end
    chk("throughput_span", 32'(span), 32'(TOTAL));
    @(negedge clk);
    chk("done_after_last", 32'(done), 1);
    chk("valid_after_last", 32'(valid_out), 0);
    // Hold finished in DONE: no restream
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_done", 32'(done), 1);
      chk("hold_valid", 32'(valid_out), 0);
    end
    @(posedge clk); #1;
    set_fin(0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_done", 32'(done), 0);
    chk("drop_busy", 32'(busy), 0);
    @(posedge clk); #1;
    fill(1);
    snap();
    set_fin(1, 1);
    stream(100, -1, TOTAL, nb, span);
    // Partial finish: must not start
    set_fin(1, 0);
    ready_in = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("partial_valid", 32'(valid_out), 0);
      @(posedge clk); #1;
    end
    fill(0);
    snap();
    set_fin(1, 1);
    @(negedge clk);
    chk("rise_same_cycle", 32'(valid_out), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rise_next_cycle", 32'(valid_out), 1);
    @(posedge clk); #1;
    // 30% ready with mat_in corrupted after beat 10
    stream(30, 11, TOTAL, nb, span);
    @(posedge clk); #1;
    set_fin(0, 0);
    repeat (2) @(posedge clk);
    #1;
    fill(1);
    snap();
    set_fin(1, 1);
    stream(100, -1, 100, nb, span);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    fill(1);
    snap();
    @(negedge clk);
    chk_idle_outs("midreset");
    @(posedge clk); #1;
    stream(60, -1, TOTAL, nb, span);
    @(negedge clk);
    chk("final_done", 32'(done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
